// File: rtl/instruction_pipeline_if.sv
// rtl/instruction_pipeline_if.sv - instruction fetch bus between the core and the memory controller
interface instruction_pipeline_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        abort;
    logic        write;
    logic        size;
    logic [1:0]  prot;
    logic [1:0]  trans;

    modport master (output addr, wdata, write, size, prot, trans, input rdata, abort);
    modport slave  (input addr, wdata, write, size, prot, trans, output rdata, abort);
endinterface

// File: rtl/instruction_pipeline.sv
// rtl/instruction_pipeline.sv - five-cycle ARM-subset fetch/decode/execute core
// Optional multiplier enabled by defining MULTIPLY_EN.
module instruction_pipeline (
    input  logic                          clk,
    input  logic                          reset,
    instruction_pipeline_if.master        bus,
    input  logic [3:0]                    dbg_idx,
    output logic [31:0]                   dbg_data,
    output logic [3:0]                    flags_o
);
    localparam logic [31:0] NOP_INSN = 32'hF000_0000;

    typedef enum logic [2:0] {S_FETCH, S_WAIT, S_DECODE, S_EXECUTE, S_WRITEBACK} state_t;
    typedef enum logic [1:0] {K_NOP, K_DP, K_MUL, K_BR} kind_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] regs_q [16];
    logic [3:0]  nzcv_q;

    kind_t       kind_q, kind_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic        sh_c_q, sh_c_d;
`ifdef MULTIPLY_EN
    logic [31:0] op_c_q, op_c_d;
`endif

    logic [31:0] res_q, res_d, pc_new_q, pc_new_d;
    logic [3:0]  nzcv_new_q, nzcv_new_d, rd_idx_q, rd_idx_d;
    logic        rd_we_q, rd_we_d, flag_we_q, flag_we_d, lr_we_q, lr_we_d;

    assign bus.addr  = reset ? 32'd0 : pc_q;
    assign bus.wdata = 32'd0;
    assign bus.write = 1'b0;
    assign bus.size  = 1'b1;
    assign bus.prot  = 2'b00;
    assign dbg_data  = (dbg_idx == 4'hF) ? pc_q : regs_q[dbg_idx];
    assign flags_o   = nzcv_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = S_FETCH;
        bus.trans = 2'b00;
        case (state_q)
            S_FETCH: begin
                state_d   = S_WAIT;
                bus.trans = reset ? 2'b00 : 2'b10;
            end
            S_WAIT:      state_d = S_DECODE;
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE:   state_d = S_WRITEBACK;
            default:     state_d = S_FETCH;
        endcase
    end

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // r15 as an operand reads as the address of this instruction plus 8
    function automatic logic [31:0] rd_reg(input logic [3:0] idx);
        return (idx == 4'hF) ? pc_q + 32'd8 : regs_q[idx];
    endfunction

    logic        is_mul, is_dp, is_br;
    logic [4:0]  rot, sh_amt;
    logic [31:0] imm_val, rm_val, sh_val;
    logic        imm_c, sh_c;
    logic [32:0] lsl_w, lsr_w, asr_w;

    always_comb begin
        rot     = {ir_q[11:8], 1'b0};
        imm_val = ({24'd0, ir_q[7:0]} >> rot) | ({24'd0, ir_q[7:0]} << (6'd32 - {1'b0, rot}));
        imm_c   = (rot != 5'd0) ? imm_val[31] : nzcv_q[1];
        rm_val  = rd_reg(ir_q[3:0]);
        sh_amt  = ir_q[11:7];
        lsl_w   = {1'b0, rm_val} << sh_amt;
        lsr_w   = {rm_val, 1'b0} >> sh_amt;
        asr_w   = $signed({rm_val, 1'b0}) >>> sh_amt;
        sh_val  = rm_val;
        sh_c    = nzcv_q[1];
        // Zero shift amounts encode LSR/ASR #32 and RRX
        case (ir_q[6:5])
            2'b00: begin
                sh_val = lsl_w[31:0];
                sh_c   = (sh_amt == 5'd0) ? nzcv_q[1] : lsl_w[32];
            end
            2'b01: begin
                sh_val = (sh_amt == 5'd0) ? 32'd0 : lsr_w[32:1];
                sh_c   = (sh_amt == 5'd0) ? rm_val[31] : lsr_w[0];
            end
            2'b10: begin
                sh_val = (sh_amt == 5'd0) ? {32{rm_val[31]}} : asr_w[32:1];
                sh_c   = (sh_amt == 5'd0) ? rm_val[31] : asr_w[0];
            end
            default: begin
                if (sh_amt == 5'd0) begin
                    sh_val = {nzcv_q[1], rm_val[31:1]};
                    sh_c   = rm_val[0];
                end else begin
                    sh_val = (rm_val >> sh_amt) | (rm_val << (6'd32 - {1'b0, sh_amt}));
                    sh_c   = sh_val[31];
                end
            end
        endcase

        is_mul = (ir_q[27:22] == 6'd0) && (ir_q[7:4] == 4'b1001);
        is_dp  = (ir_q[27:26] == 2'b00) && !(!ir_q[25] && ir_q[4]);
        is_br  = (ir_q[27:25] == 3'b101);
        kind_d = K_NOP;
        op_a_d = rd_reg(ir_q[19:16]);
        op_b_d = ir_q[25] ? imm_val : sh_val;
        sh_c_d = ir_q[25] ? imm_c : sh_c;
`ifdef MULTIPLY_EN
        op_c_d = rd_reg(ir_q[15:12]);
`endif
        if (!cond_pass(ir_q[31:28], nzcv_q)) begin
            kind_d = K_NOP;
        end else if (is_mul) begin
`ifdef MULTIPLY_EN
            kind_d = K_MUL;
            op_a_d = rm_val;
            op_b_d = rd_reg(ir_q[11:8]);
`endif
        end else if (is_dp) begin
            kind_d = K_DP;
        end else if (is_br) begin
            kind_d = K_BR;
        end
    end

    logic [3:0]  opc;
    logic [31:0] add_x, add_y, alu_res;
    logic        add_cin, is_arith, is_test;
    logic [32:0] sum;

    always_comb begin
        opc      = ir_q[24:21];
        add_x    = op_a_q;
        add_y    = op_b_q;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        case (opc)
            4'h2, 4'hA: begin add_y = ~op_b_q; add_cin = 1'b1; end
            4'h3:       begin add_x = op_b_q; add_y = ~op_a_q; add_cin = 1'b1; end
            4'h4, 4'hB: add_cin = 1'b0;
            4'h5:       add_cin = nzcv_q[1];
            4'h6:       begin add_y = ~op_b_q; add_cin = nzcv_q[1]; end
            4'h7:       begin add_x = op_b_q; add_y = ~op_a_q; add_cin = nzcv_q[1]; end
            default:    is_arith = 1'b0;
        endcase
        sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
        case (opc)
            4'h0, 4'h8: alu_res = op_a_q & op_b_q;
            4'h1, 4'h9: alu_res = op_a_q ^ op_b_q;
            4'hC:       alu_res = op_a_q | op_b_q;
            4'hD:       alu_res = op_b_q;
            4'hE:       alu_res = op_a_q & ~op_b_q;
            4'hF:       alu_res = ~op_b_q;
            default:    alu_res = sum[31:0];
        endcase
        is_test = (opc[3:2] == 2'b10);

        res_d      = 32'd0;
        nzcv_new_d = nzcv_q;
        rd_idx_d   = ir_q[15:12];
        rd_we_d    = 1'b0;
        flag_we_d  = 1'b0;
        lr_we_d    = 1'b0;
        pc_new_d   = pc_q + 32'd4;
        case (kind_q)
            K_DP: begin
                res_d         = alu_res;
                rd_we_d       = !is_test;
                flag_we_d     = is_test || (ir_q[20] && ir_q[15:12] != 4'hF);
                nzcv_new_d[3] = alu_res[31];
                nzcv_new_d[2] = (alu_res == 32'd0);
                if (is_arith) begin
                    nzcv_new_d[1] = sum[32];
                    nzcv_new_d[0] = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
                end else begin
                    nzcv_new_d[1] = sh_c_q;
                end
                if (!is_test && ir_q[15:12] == 4'hF) pc_new_d = {alu_res[31:2], 2'b00};
            end
`ifdef MULTIPLY_EN
            K_MUL: begin
                res_d         = op_a_q * op_b_q + (ir_q[21] ? op_c_q : 32'd0);
                rd_idx_d      = ir_q[19:16];
                rd_we_d       = 1'b1;
                flag_we_d     = ir_q[20] && ir_q[19:16] != 4'hF;
                nzcv_new_d[3] = res_d[31];
                nzcv_new_d[2] = (res_d == 32'd0);
                if (ir_q[19:16] == 4'hF) pc_new_d = {res_d[31:2], 2'b00};
            end
`endif
            K_BR: begin
                pc_new_d = pc_q + 32'd8 + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
                lr_we_d  = ir_q[24];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= 32'd0;
            ir_q       <= NOP_INSN;
            nzcv_q     <= 4'd0;
            for (int i = 0; i < 16; i++) regs_q[i] <= 32'd0;
            kind_q     <= K_NOP;
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            sh_c_q     <= 1'b0;
`ifdef MULTIPLY_EN
            op_c_q     <= 32'd0;
`endif
            res_q      <= 32'd0;
            pc_new_q   <= 32'd0;
            nzcv_new_q <= 4'd0;
            rd_idx_q   <= 4'd0;
            rd_we_q    <= 1'b0;
            flag_we_q  <= 1'b0;
            lr_we_q    <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT: ir_q <= bus.abort ? NOP_INSN : bus.rdata;
                S_DECODE: begin
                    kind_q <= kind_d;
                    op_a_q <= op_a_d;
                    op_b_q <= op_b_d;
                    sh_c_q <= sh_c_d;
`ifdef MULTIPLY_EN
                    op_c_q <= op_c_d;
`endif
                end
                S_EXECUTE: begin
                    res_q      <= res_d;
                    pc_new_q   <= pc_new_d;
                    nzcv_new_q <= nzcv_new_d;
                    rd_idx_q   <= rd_idx_d;
                    rd_we_q    <= rd_we_d;
                    flag_we_q  <= flag_we_d;
                    lr_we_q    <= lr_we_d;
                end
                S_WRITEBACK: begin
                    pc_q <= pc_new_q;
                    if (rd_we_q && rd_idx_q != 4'hF) regs_q[rd_idx_q] <= res_q;
                    if (lr_we_q) regs_q[14] <= pc_q + 32'd4;
                    if (flag_we_q) nzcv_q <= nzcv_new_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_pipeline.sv
// tb/tb_instruction_pipeline.sv - directed-vector bench for instruction_pipeline
module tb_instruction_pipeline;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  dbg_idx;
    logic [31:0] dbg_data;
    logic [3:0]  flags_o;

    instruction_pipeline_if bus ();

    instruction_pipeline dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.master),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data),
        .flags_o  (flags_o)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOPW = 32'hE1A0_0000;
    logic [31:0] mem [64];
    logic        abort_en;
    logic [31:0] abort_addr;
    int          total = 0;
    int          bad   = 0;

    // One-cycle-latency instruction memory with an optional abort address
    always @(posedge clk) begin
        if (bus.trans == 2'b10) begin
            bus.rdata <= mem[bus.addr[7:2]];
            bus.abort <= abort_en && (bus.addr == abort_addr);
        end else begin
            bus.abort <= 1'b0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = NOPW;
        abort_en   = 1'b0;
        abort_addr = 32'd0;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
    endtask

    task automatic step(input int n);
        repeat (5 * n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic peek(input logic [3:0] idx, output logic [31:0] v);
        dbg_idx = idx;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        clear_mem();
        mem[0] = 32'hE3A0_0005;
        hold_reset();
        total++; if (bus.addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=%h", bus.addr, 32'h0); end
        total++; if (bus.trans !== 2'b00) begin bad++; $display("FAIL rst_trans got=%b exp=%b", bus.trans, 2'b00); end
        total++; if (flags_o !== 4'h0) begin bad++; $display("FAIL rst_flags got=%b exp=%b", flags_o, 4'h0); end
        peek(4'd0, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_r0 got=%h exp=%h", v, 32'h0); end
        release_reset();
        total++; if (bus.trans !== 2'b10) begin bad++; $display("FAIL first_fetch_trans got=%b exp=%b", bus.trans, 2'b10); end
        total++; if (bus.addr !== 32'h0) begin bad++; $display("FAIL first_fetch_addr got=%h exp=%h", bus.addr, 32'h0); end
        step(1);
        peek(4'd0, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL mov_r0 got=%h exp=%h", v, 32'd5); end
        total++; if (bus.addr !== 32'h4 || bus.trans !== 2'b10) begin bad++; $display("FAIL second_fetch got=%h/%b exp=%h/%b", bus.addr, bus.trans, 32'h4, 2'b10); end
    endtask

    task automatic test_adds();
        logic [31:0] v;
        clear_mem();
        mem[0] = 32'hE3A0_0005;
        mem[1] = 32'hE3E0_2004;
        mem[2] = 32'hE090_3002;
        hold_reset();
        release_reset();
        step(3);
        peek(4'd2, v);
        total++; if (v !== 32'hFFFF_FFFB) begin bad++; $display("FAIL mvn_r2 got=%h exp=%h", v, 32'hFFFF_FFFB); end
        peek(4'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL adds_r3 got=%h exp=%h", v, 32'h0); end
        total++; if (flags_o !== 4'b0110) begin bad++; $display("FAIL adds_flags got=%b exp=%b", flags_o, 4'b0110); end
    endtask

    task automatic test_cond();
        logic [31:0] v;
        clear_mem();
        mem[0] = 32'hE3A0_0005;
        mem[1] = 32'hE350_0005;
        mem[2] = 32'h13A0_4001;
        mem[3] = 32'h03A0_4002;
        hold_reset();
        release_reset();
        step(3);
        peek(4'd4, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL movne_skip got=%h exp=%h", v, 32'h0); end
        total++; if (flags_o !== 4'b0110) begin bad++; $display("FAIL cmp_flags got=%b exp=%b", flags_o, 4'b0110); end
        step(1);
        peek(4'd4, v);
        total++; if (v !== 32'd2) begin bad++; $display("FAIL moveq_r4 got=%h exp=%h", v, 32'd2); end
        total++; if (bus.addr !== 32'h10) begin bad++; $display("FAIL cond_pc got=%h exp=%h", bus.addr, 32'h10); end
    endtask

    task automatic test_shifts();
        logic [31:0] v;
        clear_mem();
        mem[0] = 32'hE3B0_64FF;
        mem[1] = 32'hE1B0_7026;
        mem[2] = 32'hE28F_8000;
        mem[3] = 32'hE350_0001;
        mem[4] = 32'hE3A0_F040;
        hold_reset();
        release_reset();
        step(1);
        peek(4'd6, v);
        total++; if (v !== 32'hFF00_0000) begin bad++; $display("FAIL rot_imm got=%h exp=%h", v, 32'hFF00_0000); end
        total++; if (flags_o !== 4'b1010) begin bad++; $display("FAIL rot_imm_flags got=%b exp=%b", flags_o, 4'b1010); end
        step(1);
        peek(4'd7, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL lsr32 got=%h exp=%h", v, 32'h0); end
        total++; if (flags_o !== 4'b0110) begin bad++; $display("FAIL lsr32_flags got=%b exp=%b", flags_o, 4'b0110); end
        step(1);
        peek(4'd8, v);
        total++; if (v !== 32'h10) begin bad++; $display("FAIL r15_read got=%h exp=%h", v, 32'h10); end
        step(1);
        total++; if (flags_o !== 4'b1000) begin bad++; $display("FAIL cmp_borrow got=%b exp=%b", flags_o, 4'b1000); end
        step(1);
        total++; if (bus.addr !== 32'h40) begin bad++; $display("FAIL mov_pc got=%h exp=%h", bus.addr, 32'h40); end
    endtask

    task automatic test_branch();
        logic [31:0] v;
        clear_mem();
        mem[4] = 32'hEA00_0002;
        mem[8] = 32'hEBFF_FFFE;
        hold_reset();
        release_reset();
        step(5);
        total++; if (bus.addr !== 32'h20) begin bad++; $display("FAIL b_target got=%h exp=%h", bus.addr, 32'h20); end
        step(1);
        total++; if (bus.addr !== 32'h20) begin bad++; $display("FAIL bl_target got=%h exp=%h", bus.addr, 32'h20); end
        peek(4'd14, v);
        total++; if (v !== 32'h24) begin bad++; $display("FAIL bl_lr got=%h exp=%h", v, 32'h24); end
        step(1);
        total++; if (bus.addr !== 32'h20) begin bad++; $display("FAIL bl_loop got=%h exp=%h", bus.addr, 32'h20); end
    endtask

    task automatic test_multiply();
        logic [31:0] v;
        logic [31:0] exp_mul, exp_mla;
`ifdef MULTIPLY_EN
        exp_mul = 32'd25;
        exp_mla = 32'd50;
`else
        exp_mul = 32'd0;
        exp_mla = 32'd0;
`endif
        clear_mem();
        mem[0] = 32'hE3A0_0005;
        mem[1] = 32'hE005_0090;
        mem[2] = 32'hE029_5090;
        hold_reset();
        release_reset();
        step(2);
        peek(4'd5, v);
        total++; if (v !== exp_mul) begin bad++; $display("FAIL mul_r5 got=%h exp=%h", v, exp_mul); end
        total++; if (bus.addr !== 32'h8) begin bad++; $display("FAIL mul_pc got=%h exp=%h", bus.addr, 32'h8); end
        step(1);
        peek(4'd9, v);
        total++; if (v !== exp_mla) begin bad++; $display("FAIL mla_r9 got=%h exp=%h", v, exp_mla); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        clear_mem();
        mem[0] = 32'hE350_0000;
        mem[1] = 32'hE3A0_0007;
        hold_reset();
        release_reset();
        step(1);
        total++; if (flags_o !== 4'b0110) begin bad++; $display("FAIL pre_flags got=%b exp=%b", flags_o, 4'b0110); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (bus.addr !== 32'h0 || bus.trans !== 2'b00) begin bad++; $display("FAIL mid_rst_bus got=%h/%b exp=%h/%b", bus.addr, bus.trans, 32'h0, 2'b00); end
        @(posedge clk);
        @(negedge clk);
        peek(4'd0, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_rst_r0 got=%h exp=%h", v, 32'h0); end
        total++; if (flags_o !== 4'h0) begin bad++; $display("FAIL mid_rst_flags got=%b exp=%b", flags_o, 4'h0); end
        release_reset();
        total++; if (bus.addr !== 32'h0 || bus.trans !== 2'b10) begin bad++; $display("FAIL mid_rst_refetch got=%h/%b exp=%h/%b", bus.addr, bus.trans, 32'h0, 2'b10); end
    endtask

    task automatic test_abort();
        logic [31:0] v;
        clear_mem();
        mem[0] = 32'hE3A0_0003;
        mem[1] = 32'hE3A0_0005;
        mem[2] = 32'hE3A0_1009;
        hold_reset();
        abort_en   = 1'b1;
        abort_addr = 32'h4;
        release_reset();
        step(1);
        peek(4'd0, v);
        total++; if (v !== 32'd3) begin bad++; $display("FAIL pre_abort_r0 got=%h exp=%h", v, 32'd3); end
        step(1);
        peek(4'd0, v);
        total++; if (v !== 32'd3) begin bad++; $display("FAIL abort_r0 got=%h exp=%h", v, 32'd3); end
        total++; if (bus.addr !== 32'h8) begin bad++; $display("FAIL abort_pc got=%h exp=%h", bus.addr, 32'h8); end
        step(1);
        peek(4'd1, v);
        total++; if (v !== 32'd9) begin bad++; $display("FAIL post_abort_r1 got=%h exp=%h", v, 32'd9); end
    endtask

    initial begin
        dbg_idx = 4'd0;
        test_reset();
        test_adds();
        test_cond();
        test_shifts();
        test_branch();
        test_multiply();
        test_reset_mid();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
